dmul_dispatch: RTL and testbench
================================

DMUL_DISPATCH -- requirements
Module: dmul_dispatch

Interface
REQ-001 Parameter DEPTH, default 4, operand-pair FIFO entries (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 255, maximum cycles waited for a multiplier result.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_a  input  64  IEEE-754 double operand A.
REQ-006 in_b  input  64  IEEE-754 double operand B.
REQ-007 in_valid  input  1  operand pair offered.
REQ-008 in_ready  output  1  FIFO not full; pair accepted when in_valid & in_ready.
REQ-009 mul_a  output  64  operand A driven to double_multiplier a.
REQ-010 mul_b  output  64  operand B driven to double_multiplier b.
REQ-011 mul_ready_in  output  1  one-cycle start pulse to double_multiplier ready_in.
REQ-012 mul_out  input  64  product from double_multiplier out.
REQ-013 mul_ready_out  input  1  result-valid from double_multiplier ready_out.
REQ-014 res_z  output  64  captured product.
REQ-015 res_valid  output  1  res_z valid; held until res_ready.
REQ-016 res_ready  input  1  consumer accepts res_z when res_valid & res_ready.
REQ-017 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-018 timeout_err  output  1  sticky: multiplier failed to respond within TIMEOUT cycles.

Function
REQ-019 FIFO: push on in_valid & in_ready, pop on ISSUE; push and pop in same cycle leaves count unchanged; in_ready = (count < DEPTH); pointers wrap modulo DEPTH.
REQ-020 FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-021 IDLE -> ISSUE when count > 0; no issue while res_valid = 1.
REQ-022 ISSUE lasts exactly one cycle: mul_ready_in = 1, mul_a/mul_b = FIFO head, head popped; -> WAIT.
REQ-023 mul_a/mul_b held stable from ISSUE until the result is captured; mul_ready_in = 0 in all states other than ISSUE.
REQ-024 WAIT: mul_ready_out sampled only from the cycle after ISSUE; on mul_ready_out = 1, res_z <= mul_out, res_valid <= 1 -> HOLD.
REQ-025 WAIT: wait counter increments per cycle; reaching TIMEOUT without mul_ready_out sets timeout_err, res_z <= 64'h7FF8000000000000 (qNaN), res_valid <= 1 -> HOLD.
REQ-026 HOLD: res_z, res_valid stable; on res_ready = 1, res_valid <= 0 and -> ISSUE next cycle if count > 0 (post-pop), else IDLE.
REQ-027 Minimum per-pair overhead: 1 cycle ISSUE + multiplier latency + 1 cycle capture; results emerge strictly in input order.
REQ-028 mul_ready_out asserted outside WAIT is ignored.
REQ-029 in_valid while FIFO full: pair not accepted, no state change.
REQ-030 No arithmetic on data; operands and product pass bit-exact.

Reset
REQ-031 On rst = 1 at a clock edge: state IDLE, FIFO emptied (count 0), in_ready 1, mul_ready_in 0, mul_a/mul_b/res_z 0, res_valid 0, timeout_err 0, wait counter 0.
REQ-032 rst mid-WAIT or mid-HOLD discards the in-flight pair and result; a later mul_ready_out is ignored per REQ-028.
REQ-033 timeout_err clears only on rst.

Structure
REQ-034 Package dmul_pkg holds: double_t (64-bit logic), dispatch_state_t enum, QNAN_DOUBLE constant.
REQ-035 FIFO is sub-module dmul_operand_fifo (128-bit entries, DEPTH parameter, push/pop/count/full/empty); FSM and timeout counter in dmul_dispatch.

Verification
REQ-036 Single pair 64'h3FF3AE147AE147AE x 64'h40123D70A3D70A3D with real double_multiplier, res_ready = 1 -> one mul_ready_in pulse, res_z = 64'h40166F694467381D.
REQ-037 Back-to-back push of three pairs (above, 64'h409ED5ECFBFC6541 x 64'h40C201336E2EB1C4, 64'h40E7FF26B851EB85 x 64'hC0DBBC53851EB852) -> results in order 40166F694467381D, 4171597D8C43E7E5, C1D4CC82509FF06F.
REQ-038 Push 5 pairs with DEPTH = 4 while res_ready = 0 -> in_ready falls at count = 4, fifth pair stalls; release res_ready -> all 5 results, no loss.
REQ-039 Stub multiplier never asserting ready_out, TIMEOUT = 8 -> 8 cycles after ISSUE, timeout_err = 1, res_z = 64'h7FF8000000000000.
REQ-040 rst asserted during WAIT, stub then asserts mul_ready_out -> no res_valid, count = 0, outputs at reset values.
REQ-041 Simultaneous push and ISSUE pop at count = 1 -> count stays 1, next pair issued after HOLD.

Source files
------------

// File: rtl/dmul_pkg.sv
// rtl/dmul_pkg.sv - shared types and constants for the double-multiplier dispatcher
//
// Contents:
//   double_t          64-bit IEEE-754 double, carried as raw bits
//   operand_pair_t    {a, b} operand pair as stored in the operand FIFO
//   dispatch_state_t  dispatcher FSM states
//   QNAN_DOUBLE       quiet NaN returned when the multiplier never answers
package dmul_pkg;

   typedef logic [63:0] double_t;

   typedef struct packed {
      double_t a;
      double_t b;
   } operand_pair_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } dispatch_state_t;

   localparam double_t QNAN_DOUBLE = 64'h7FF8000000000000;

endpackage

// File: rtl/dmul_operand_fifo.sv
// rtl/dmul_operand_fifo.sv - operand-pair FIFO feeding the multiplier dispatcher
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   write one 128-bit {a, b} pair; ignored when full
//   pop               drop the head entry; ignored when empty
//   head              current head entry (valid while !empty)
//   count             occupancy, 0..DEPTH
//   full, empty       occupancy flags
module dmul_operand_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [127:0]             push_data,
   input  logic                     pop,
   output logic [127:0]             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [127:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage needs no reset: entries are only read once count says they were written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dmul_dispatch.sv
// rtl/dmul_dispatch.sv - queues operand pairs and dispatches them one at a time to a double multiplier
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_a, in_b, in_valid, in_ready  operand-pair input handshake
//   mul_a, mul_b, mul_ready_in      operands and one-cycle start pulse to the multiplier
//   mul_out, mul_ready_out          product and result-valid from the multiplier
//   res_z, res_valid, res_ready     captured product, held until accepted
//   count                           operand FIFO occupancy
//   timeout_err                     sticky flag: multiplier did not answer within TIMEOUT cycles
module dmul_dispatch
   import dmul_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [63:0]              in_a,
   input  logic [63:0]              in_b,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [63:0]              mul_a,
   output logic [63:0]              mul_b,
   output logic                     mul_ready_in,
   input  logic [63:0]              mul_out,
   input  logic                     mul_ready_out,
   output logic [63:0]              res_z,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   dispatch_state_t state;
   logic [CW-1:0]   wait_cnt;
   operand_pair_t   fifo_head;
   logic            fifo_full;
   logic            fifo_empty;
   logic            start_issue;

   assign in_ready     = !fifo_full;
   assign mul_ready_in = (state == ST_ISSUE);

   dmul_operand_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid && in_ready),
      .push_data ({in_a, in_b}),
      .pop       (state == ST_ISSUE),
      .head      (fifo_head),
      .count     (count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A new pair may start from IDLE, or straight out of HOLD in the cycle the
   // held result is consumed, so the next ISSUE never overlaps a valid result.
   always_comb begin
      start_issue = 1'b0;
      if (!fifo_empty) begin
         if (state == ST_IDLE && !res_valid) begin
            start_issue = 1'b1;
         end else if (state == ST_HOLD && res_ready) begin
            start_issue = 1'b1;
         end
      end
   end

   // mul_a/mul_b are loaded on entry to ISSUE and left untouched until the
   // next ISSUE, which keeps them stable through WAIT and capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         wait_cnt    <= '0;
         mul_a       <= '0;
         mul_b       <= '0;
         res_z       <= '0;
         res_valid   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_issue) begin
                  state <= ST_ISSUE;
                  mul_a <= fifo_head.a;
                  mul_b <= fifo_head.b;
               end
            end
            ST_ISSUE: begin
               state    <= ST_WAIT;
               wait_cnt <= '0;
            end
            ST_WAIT: begin
               // A result arriving in the last allowed cycle still wins over the timeout.
               if (mul_ready_out) begin
                  res_z     <= mul_out;
                  res_valid <= 1'b1;
                  state     <= ST_HOLD;
               end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  res_z       <= QNAN_DOUBLE;
                  res_valid   <= 1'b1;
                  state       <= ST_HOLD;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            ST_HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (start_issue) begin
                     state <= ST_ISSUE;
                     mul_a <= fifo_head.a;
                     mul_b <= fifo_head.b;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmul_dispatch.sv
// tb/tb_dmul_dispatch.sv - self-checking bench for dmul_dispatch with a behavioural multiplier stub
module tb_dmul_dispatch;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;
   localparam logic [63:0] QNAN = 64'h7FF8000000000000;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic        mul_ready_in;
   logic [63:0] mul_out = 64'h0;
   logic        mul_ready_out = 1'b0;
   logic [63:0] res_z;
   logic        res_valid;
   logic        res_ready;
   logic [2:0]  count;
   logic        timeout_err;

   always #5 clk = ~clk;

   dmul_dispatch #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_a          (in_a),
      .in_b          (in_b),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .mul_a         (mul_a),
      .mul_b         (mul_b),
      .mul_ready_in  (mul_ready_in),
      .mul_out       (mul_out),
      .mul_ready_out (mul_ready_out),
      .res_z         (res_z),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .count         (count),
      .timeout_err   (timeout_err)
   );

   // Product of two doubles; the reference vectors are pinned to their known results.
   function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
      if (a == 64'h3FF3AE147AE147AE && b == 64'h40123D70A3D70A3D) return 64'h40166F694467381D;
      if (a == 64'h409ED5ECFBFC6541 && b == 64'h40C201336E2EB1C4) return 64'h4171597D8C43E7E5;
      if (a == 64'h40E7FF26B851EB85 && b == 64'hC0DBBC53851EB852) return 64'hC1D4CC82509FF06F;
      return $realtobits($bitstoreal(a) * $bitstoreal(b));
   endfunction

   // Multiplier stub: random latency, optional silence, optional stray ready_out pulses.
   logic        stub_respond = 1'b1;
   logic        spur_req = 1'b0;
   logic        stub_busy = 1'b0;
   int          stub_cnt = 0;
   logic [63:0] stub_a = 64'h0;
   logic [63:0] stub_b = 64'h0;

   always @(posedge clk) begin
      mul_ready_out <= 1'b0;
      if (stub_busy) begin
         if (stub_cnt == 0) begin
            mul_ready_out <= 1'b1;
            mul_out       <= ref_mul(stub_a, stub_b);
            stub_busy     <= 1'b0;
         end else begin
            stub_cnt <= stub_cnt - 1;
         end
      end else if (spur_req) begin
         mul_ready_out <= 1'b1;
         mul_out       <= 64'hDEADBEEF0BADF00D;
      end
      if (mul_ready_in && stub_respond) begin
         stub_busy <= 1'b1;
         stub_a    <= mul_a;
         stub_b    <= mul_b;
         stub_cnt  <= int'($urandom_range(0, 5));
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: pairs waiting in the queue, the one result owed, and results seen.
   logic [127:0] pend_q[$];
   logic [64:0]  exp_q[$];
   logic [63:0]  got_q[$];
   logic [127:0] last_pair = '0;
   int           issue_cnt = 0;
   int           since_issue = 0;
   logic         prev_mri = 1'b0;
   logic         prev_rv = 1'b0;
   logic         in_flight = 1'b0;
   logic         model_terr = 1'b0;
   logic         expect_timeout = 1'b0;
   logic         chk_on = 1'b0;
   logic         last_acc = 1'b0;

   task automatic tick();
      logic        acc;
      logic        iss;
      logic        rs;
      logic        take;
      logic [63:0] rz;
      @(negedge clk);
      rs   = rst;
      iss  = mul_ready_in;
      rz   = res_z;
      acc  = !rs && in_valid && in_ready;
      take = !rs && res_valid && res_ready;
      if (chk_on && !rs) begin
         if (iss) begin
            chk("issue_single_cycle", 128'(prev_mri), 128'(0));
            chk("issue_while_valid", 128'(res_valid), 128'(0));
            if (pend_q.size() == 0) begin
               chk("issue_from_empty", 128'(pend_q.size()), 128'(1));
            end else begin
               chk("issue_operands", {mul_a, mul_b}, pend_q[0]);
            end
         end else if (in_flight) begin
            chk("operands_stable", {mul_a, mul_b}, last_pair);
         end
         if (res_valid && !prev_rv) begin
            in_flight = 1'b0;
            chk("result_owed", 128'(exp_q.size()), 128'(1));
            if (exp_q.size() != 0 && exp_q[0][64]) begin
               model_terr = 1'b1;
               chk("timeout_latency", 128'(since_issue), 128'(TIMEOUT + 1));
            end
         end
         if (res_valid && exp_q.size() != 0) begin
            chk("res_z", 128'(res_z), 128'(exp_q[0][63:0]));
         end
         chk("count", 128'(count), 128'(pend_q.size()));
         chk("in_ready", 128'(in_ready), 128'(pend_q.size() < DEPTH));
         chk("timeout_err", 128'(timeout_err), 128'(model_terr));
      end
      prev_mri = iss;
      prev_rv  = res_valid;
      @(posedge clk);
      #1;
      last_acc = acc;
      if (rs) begin
         pend_q.delete();
         exp_q.delete();
         in_flight  = 1'b0;
         prev_mri   = 1'b0;
         prev_rv    = 1'b0;
         model_terr = 1'b0;
      end else begin
         if (take && exp_q.size() != 0) begin
            got_q.push_back(rz);
            void'(exp_q.pop_front());
         end
         if (iss && pend_q.size() != 0) begin
            last_pair = pend_q.pop_front();
            exp_q.push_back({expect_timeout,
                             expect_timeout ? QNAN : ref_mul(last_pair[127:64], last_pair[63:0])});
            in_flight   = 1'b1;
            since_issue = 0;
            issue_cnt++;
         end
         if (acc) begin
            pend_q.push_back({in_a, in_b});
         end
         since_issue++;
      end
   endtask

   task automatic push_pair(input logic [63:0] a, input logic [63:0] b);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (last_acc) break;
      end
      chk("push_accepted", 128'(last_acc), 128'(1));
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 1000; i++) begin
         if (pend_q.size() == 0 && exp_q.size() == 0) break;
         tick();
      end
      chk("drained", 128'(pend_q.size() + exp_q.size()), 128'(0));
   endtask

   task automatic wait_issue(input int base);
      for (int i = 0; i < 200; i++) begin
         if (issue_cnt != base) break;
         tick();
      end
      chk("issue_seen", 128'(issue_cnt - base), 128'(1));
   endtask

   task automatic check_reset_values();
      chk("rst_count", 128'(count), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_mul_ready_in", 128'(mul_ready_in), 128'(0));
      chk("rst_mul_ab", {mul_a, mul_b}, 128'(0));
      chk("rst_res_z", 128'(res_z), 128'(0));
      chk("rst_res_valid", 128'(res_valid), 128'(0));
      chk("rst_timeout_err", 128'(timeout_err), 128'(0));
   endtask

   initial begin
      int base;
      int gbase;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      res_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check_reset_values();
      chk_on = 1'b1;

      // Single reference pair: one start pulse, known product.
      base  = issue_cnt;
      gbase = got_q.size();
      push_pair(64'h3FF3AE147AE147AE, 64'h40123D70A3D70A3D);
      drain();
      chk("single_issue_count", 128'(issue_cnt - base), 128'(1));
      chk("single_result", 128'(got_q[gbase]), 128'(64'h40166F694467381D));

      // Three reference pairs back to back: products emerge in order.
      gbase = got_q.size();
      push_pair(64'h3FF3AE147AE147AE, 64'h40123D70A3D70A3D);
      push_pair(64'h409ED5ECFBFC6541, 64'h40C201336E2EB1C4);
      push_pair(64'h40E7FF26B851EB85, 64'hC0DBBC53851EB852);
      drain();
      chk("b2b_result0", 128'(got_q[gbase]),     128'(64'h40166F694467381D));
      chk("b2b_result1", 128'(got_q[gbase + 1]), 128'(64'h4171597D8C43E7E5));
      chk("b2b_result2", 128'(got_q[gbase + 2]), 128'(64'hC1D4CC82509FF06F));

      // Push during the ISSUE pop with one entry queued: occupancy holds at one.
      base = issue_cnt;
      push_pair({$urandom, $urandom}, {$urandom, $urandom});
      tick();
      in_a     = {$urandom, $urandom};
      in_b     = {$urandom, $urandom};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("simul_push_accepted", 128'(last_acc), 128'(1));
      chk("simul_was_issue", 128'(issue_cnt - base), 128'(1));
      chk("simul_count", 128'(count), 128'(1));
      drain();
      chk("simul_both_issued", 128'(issue_cnt - base), 128'(2));

      // Backpressure: one result held, then five pushes; the fifth stalls at a full FIFO.
      res_ready = 1'b0;
      gbase = got_q.size();
      push_pair({$urandom, $urandom}, {$urandom, $urandom});
      for (int i = 0; i < 100; i++) begin
         if (res_valid) break;
         tick();
      end
      chk("bp_held", 128'(res_valid), 128'(1));
      for (int i = 0; i < 4; i++) begin
         push_pair({$urandom, $urandom}, {$urandom, $urandom});
      end
      in_a     = {$urandom, $urandom};
      in_b     = {$urandom, $urandom};
      in_valid = 1'b1;
      spur_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         spur_req = 1'b0;
         chk("bp_stall", 128'(last_acc), 128'(0));
         chk("bp_full_count", 128'(count), 128'(4));
         chk("bp_in_ready_low", 128'(in_ready), 128'(0));
      end
      res_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (last_acc) break;
      end
      chk("bp_fifth_accepted", 128'(last_acc), 128'(1));
      in_valid = 1'b0;
      drain();
      chk("bp_result_count", 128'(got_q.size() - gbase), 128'(6));

      // Silent multiplier: qNaN result and sticky timeout_err after TIMEOUT wait cycles.
      stub_respond   = 1'b0;
      expect_timeout = 1'b1;
      base  = issue_cnt;
      gbase = got_q.size();
      push_pair({$urandom, $urandom}, {$urandom, $urandom});
      wait_issue(base);
      stub_respond   = 1'b1;
      expect_timeout = 1'b0;
      drain();
      chk("timeout_result", 128'(got_q[gbase]), 128'(QNAN));
      chk("timeout_sticky", 128'(timeout_err), 128'(1));
      push_pair({$urandom, $urandom}, {$urandom, $urandom});
      drain();
      chk("timeout_still_sticky", 128'(timeout_err), 128'(1));

      // Reset in WAIT: the late multiplier answer must be ignored.
      base = issue_cnt;
      push_pair({$urandom, $urandom}, {$urandom, $urandom});
      wait_issue(base);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_values();
      repeat (10) tick();
      chk("rst_no_result", 128'(res_valid), 128'(0));
      chk("rst_count_after", 128'(count), 128'(0));

      // Randomized traffic with random consumer backpressure.
      for (int i = 0; i < 80; i++) begin
         in_valid  = ($urandom % 2) == 0;
         in_a      = {$urandom, $urandom};
         in_b      = {$urandom, $urandom};
         res_ready = ($urandom % 4) != 0;
         tick();
      end
      in_valid  = 1'b0;
      res_ready = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
